// File: rtl/keycode_event_queue.sv
// Debounces a raw HID keycode and turns each accepted change into release/press
// events, queued in a show-ahead FIFO with a sticky overflow flag.
module keycode_event_queue #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [7:0]               keycode,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [8:0]               ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  output logic [7:0]               cur_key
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PRESS = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [7:0]     keycode_q;
  logic [7:0]     cand;
  logic [SW-1:0]  stab_cnt;
  logic [7:0]     pend;
  logic           accept;
  logic           push;
  logic [8:0]     push_data;

  logic [8:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           pop;
  logic           wr_en;

  // Input capture and stability tracking of the candidate keycode
  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode_q <= 8'h00;
      cand      <= 8'h00;
      stab_cnt  <= SW'(0);
    end else begin
      keycode_q <= keycode;
      if (keycode_q != cand) begin
        cand     <= keycode_q;
        stab_cnt <= SW'(1);
      end else if (stab_cnt != SW'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + SW'(1);
      end
    end
  end

  // A candidate is taken only when it has held long enough and differs from the current key
  assign accept = (state == IDLE) && (keycode_q == cand) &&
                  (stab_cnt == SW'(STABLE_CYCLES)) && (cand != cur_key);

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a key-to-key change needs a second edge for the press
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && (cur_key != 8'h00) && (cand != 8'h00)) begin
          state_nxt = PRESS;
        end
      end
      PRESS:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: event generation
  always_comb begin
    push      = 1'b0;
    push_data = 9'h000;
    case (state)
      IDLE: begin
        if (accept) begin
          push = 1'b1;
          if (cur_key != 8'h00) begin
            push_data = {1'b0, cur_key};
          end else begin
            push_data = {1'b1, cand};
          end
        end
      end
      PRESS: begin
        push      = 1'b1;
        push_data = {1'b1, pend};
      end
      default: begin
        push      = 1'b0;
        push_data = 9'h000;
      end
    endcase
  end

  // Current key and the press held back for the PRESS state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_key <= 8'h00;
      pend    <= 8'h00;
    end else if (accept) begin
      cur_key <= cand;
      pend    <= cand;
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign pop   = ev_valid && ev_ready;
  assign wr_en = push && (!full || pop);

  // FIFO storage; pointers are already cleared during reset so no write is needed then
  always_ff @(posedge Clk) begin
    if (!Reset && wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= AW'(0);
      rd_ptr   <= AW'(0);
      count    <= CW'(0);
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !pop) begin
        count <= count + CW'(1);
      end else if (!wr_en && pop) begin
        count <= count - CW'(1);
      end
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ev_valid = (count != CW'(0));
  assign ev_data  = ev_valid ? mem[rd_ptr] : 9'h000;
  assign ev_count = count;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Bench for keycode_event_queue: directed vector table, hand sequences for the
// overflow and reset-in-PRESS cases, and random stimulus against an event model.
module tb_keycode_event_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned S     = 4;

  logic       clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       ev_ready;
  logic       ev_valid;
  logic [8:0] ev_data;
  logic [3:0] ev_count;
  logic       overflow;
  logic [7:0] cur_key;

  int n_checks = 0;
  int n_fail   = 0;

  keycode_event_queue #(.DEPTH(DEPTH), .STABLE_CYCLES(S)) dut (
    .Clk      (clk),
    .Reset    (Reset),
    .keycode  (keycode),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .ev_count (ev_count),
    .overflow (overflow),
    .cur_key  (cur_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a key is taken once the last S+1 samples agree
  logic [7:0] hist [$];
  logic [8:0] m_fifo [$];
  logic [7:0] m_cur;
  bit         m_pend_v;
  logic [7:0] m_pend;
  bit         m_ovf;

  task automatic model_step(input bit rst, input logic [7:0] k, input bit rdy);
    bit         acc;
    bit         have_ev;
    bit         do_pop;
    logic [8:0] ev;
    logic [7:0] nk;
    if (rst) begin
      hist.delete();
      m_fifo.delete();
      m_cur    = 8'h00;
      m_pend_v = 1'b0;
      m_pend   = 8'h00;
      m_ovf    = 1'b0;
      return;
    end
    have_ev = 1'b0;
    ev      = 9'h000;
    acc     = 1'b0;
    nk      = 8'h00;
    if (!m_pend_v && hist.size() == int'(S) + 1) begin
      acc = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) acc = 1'b0;
      if (hist[0] == m_cur) acc = 1'b0;
    end
    if (m_pend_v) begin
      have_ev  = 1'b1;
      ev       = {1'b1, m_pend};
      m_pend_v = 1'b0;
    end else if (acc) begin
      nk      = hist[0];
      have_ev = 1'b1;
      if (m_cur != 8'h00) begin
        ev = {1'b0, m_cur};
        if (nk != 8'h00) begin
          m_pend_v = 1'b1;
          m_pend   = nk;
        end
      end else begin
        ev = {1'b1, nk};
      end
      m_cur = nk;
    end
    do_pop = (m_fifo.size() > 0) && rdy;
    if (do_pop) void'(m_fifo.pop_front());
    if (have_ev) begin
      if (m_fifo.size() < int'(DEPTH)) m_fifo.push_back(ev);
      else m_ovf = 1'b1;
    end
    hist.push_back(k);
    if (hist.size() > int'(S) + 1) void'(hist.pop_front());
  endtask

  function automatic logic [22:0] model_snap();
    logic [8:0] d;
    d = (m_fifo.size() > 0) ? m_fifo[0] : 9'h000;
    return {m_fifo.size() > 0, d, 4'(m_fifo.size()), m_ovf, m_cur};
  endfunction

  function automatic logic [22:0] dut_snap();
    return {ev_valid, ev_data, ev_count, overflow, cur_key};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b data=%h count=%0d ovf=%b cur=%h, expected valid=%b data=%h count=%0d ovf=%b cur=%h",
               name, act[22], act[21:13], act[12:9], act[8], act[7:0],
               exp[22], exp[21:13], exp[12:9], exp[8], exp[7:0]);
    end
  endtask

  // One clock edge with given inputs, then compare against the model
  task automatic tick(input bit rst, input logic [7:0] k, input bit rdy);
    Reset    = rst;
    keycode  = k;
    ev_ready = rdy;
    model_step(rst, k, rdy);
    @(posedge clk);
    #1;
    check("model", dut_snap(), model_snap());
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] k;
    bit         rdy;
    int         n;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input bit rst, input logic [7:0] k, input bit rdy, input int n,
                     input logic v, input logic [8:0] d, input logic [3:0] c,
                     input logic o, input logic [7:0] cur);
    vec_t r;
    r.rst = rst; r.k = k; r.rdy = rdy; r.n = n;
    r.exp = {v, d, c, o, cur};
    vecs.push_back(r);
  endtask

  initial begin
    Reset    = 1'b1;
    keycode  = 8'h00;
    ev_ready = 1'b0;

    // rst, key, ready, edges | valid, data, count, ovf, cur_key
    add(1, 8'h00, 0,  2, 0, 9'h000, 4'd0, 0, 8'h00);
    add(0, 8'h00, 0, 20, 0, 9'h000, 4'd0, 0, 8'h00);
    add(0, 8'h1A, 0,  5, 0, 9'h000, 4'd0, 0, 8'h00);
    add(0, 8'h1A, 0,  1, 1, 9'h11A, 4'd1, 0, 8'h1A);
    add(0, 8'h1A, 1,  1, 0, 9'h000, 4'd0, 0, 8'h1A);
    add(0, 8'h04, 0,  6, 1, 9'h01A, 4'd1, 0, 8'h04);
    add(0, 8'h04, 0,  1, 1, 9'h01A, 4'd2, 0, 8'h04);
    add(0, 8'h04, 1,  1, 1, 9'h104, 4'd1, 0, 8'h04);
    add(0, 8'h04, 1,  1, 0, 9'h000, 4'd0, 0, 8'h04);
    add(0, 8'h00, 1,  6, 1, 9'h004, 4'd1, 0, 8'h00);
    add(0, 8'h00, 1,  1, 0, 9'h000, 4'd0, 0, 8'h00);
    add(0, 8'h07, 0,  3, 0, 9'h000, 4'd0, 0, 8'h00);
    add(0, 8'h00, 0,  8, 0, 9'h000, 4'd0, 0, 8'h00);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) tick(vecs[i].rst, vecs[i].k, vecs[i].rdy);
      check($sformatf("vec%0d", i), dut_snap(), vecs[i].exp);
    end

    // Nine alternating changes overfill the queue; then push and pop on the same full edge
    tick(1, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < 8; c++) tick(0, (i % 2 == 0) ? 8'h04 : 8'h00, 0);
    end
    check("overflow_full", dut_snap(), {1'b1, 9'h104, 4'd8, 1'b1, 8'h04});
    for (int c = 0; c < 5; c++) tick(0, 8'h00, 0);
    tick(0, 8'h00, 1);
    check("full_push_pop", dut_snap(), {1'b1, 9'h004, 4'd8, 1'b1, 8'h00});
    for (int c = 0; c < 2; c++) tick(0, 8'h00, 0);

    // Reset on the PRESS edge of a 0x04->0x16 change, key still held afterwards
    for (int c = 0; c < 8; c++) tick(0, 8'h04, 0);
    check("press_dropped", dut_snap(), {1'b1, 9'h004, 4'd8, 1'b1, 8'h04});
    for (int c = 0; c < 6; c++) tick(0, 8'h16, 0);
    tick(1, 8'h16, 0);
    check("reset_in_press", dut_snap(), {1'b0, 9'h000, 4'd0, 1'b0, 8'h00});
    for (int c = 0; c < 5; c++) tick(0, 8'h16, 0);
    check("held_pre_latency", dut_snap(), {1'b0, 9'h000, 4'd0, 1'b0, 8'h00});
    tick(0, 8'h16, 0);
    check("held_fresh_press", dut_snap(), {1'b1, 9'h116, 4'd1, 1'b0, 8'h16});

    // Random keys with random hold times, consumer back-pressure and rare resets
    for (int seg = 0; seg < 300; seg++) begin
      logic [7:0] k;
      int         hold;
      int         bias;
      case ($urandom_range(0, 4))
        0:       k = 8'h00;
        1:       k = 8'h04;
        2:       k = 8'h16;
        3:       k = 8'h1A;
        default: k = 8'h00;
      endcase
      hold = int'($urandom_range(1, 9));
      bias = int'($urandom_range(0, 3));
      for (int c = 0; c < hold; c++) begin
        tick($urandom_range(0, 199) == 0, k, int'($urandom_range(0, 3)) < bias);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keycode_event_queue.md
KEYCODE_EVENT_QUEUE -- requirements
Module: keycode_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, consecutive cycles a keycode must hold before it is accepted (>=1).
REQ-003 SHALL have port Clk  input  1  system clock; the block has one clock; reset is synchronous and active-high.
REQ-004 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port keycode  input  8  raw USB HID keycode from the Nios keycode PIO; 0x00 means no key.
REQ-006 SHALL have port ev_ready  input  1  consumer accepts the head event this cycle.
REQ-007 SHALL have port ev_valid  output  1  FIFO non-empty; head event is on ev_data.
REQ-008 SHALL have port ev_data  output  9  head event {pressed, code[7:0]}; 1 = press, 0 = release.
REQ-009 SHALL have port ev_count  output  $clog2(DEPTH)+1  number of stored events.
REQ-010 SHALL have port overflow  output  1  sticky flag: an event was dropped.
REQ-011 SHALL have port cur_key  output  8  last accepted (debounced) keycode.

Function
REQ-012 SHALL register keycode into keycode_q every cycle.
REQ-013 SHALL keep candidate cand and saturating counter stab_cnt: if keycode_q != cand then cand <= keycode_q and stab_cnt <= 1; otherwise stab_cnt increments and saturates at STABLE_CYCLES.
REQ-014 SHALL accept cand when keycode_q == cand, stab_cnt == STABLE_CYCLES, cand != cur_key and the FSM is in IDLE; cur_key <= cand on the accepting edge.
REQ-015 SHALL implement FSM states IDLE and PRESS; a push and its state transition occur on the same edge.
REQ-016 IDLE on accept with cur_key != 0: push {0,cur_key}; go to PRESS with pend <= cand if cand != 0, else stay in IDLE.
REQ-017 IDLE on accept with cur_key == 0: push {1,cand} and stay in IDLE.
REQ-018 PRESS: push {1,pend} and return to IDLE on the next edge; acceptance is blocked while in PRESS.
REQ-019 Latency: with the FIFO empty, the first event SHALL be visible on ev_valid/ev_data after the (STABLE_CYCLES+2)th rising edge following the input change; the second event of a release/press pair is pushed one edge later.
REQ-020 FIFO SHALL be show-ahead; a pop occurs on an edge where ev_valid && ev_ready.
REQ-021 Push while full without a simultaneous pop: the event SHALL be dropped, overflow set, count unchanged; the FSM and cur_key still advance (no stall).
REQ-022 Simultaneous push and pop while full: both SHALL occur; count stays DEPTH; overflow unchanged.
REQ-023 ev_ready while empty SHALL be ignored; a push into an empty FIFO makes ev_valid 1 on the following cycle.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; ev_count SHALL equal the number of pushes minus pops and never exceed DEPTH.
REQ-025 overflow SHALL clear only on Reset.

Reset
REQ-026 On a Clk edge with Reset=1, the block SHALL clear keycode_q, cand, stab_cnt, pend, the pointers and overflow; set FSM to IDLE; and drive ev_valid=0, ev_data=0, ev_count=0, overflow=0, cur_key=0x00.
REQ-027 Reset during PRESS SHALL discard the pending press; a key still held after reset SHALL produce a fresh press event after the normal stability latency.
REQ-028 Reset SHALL take priority over push and pop in the same cycle.

Verification
REQ-029 Reset, then keycode=0x00 for 20 cycles -> ev_valid=0, ev_count=0, cur_key=0x00.
REQ-030 With STABLE_CYCLES=4 and ev_ready=0, keycode 0x00->0x1A -> after 6 edges ev_valid=1, ev_data=0x11A, ev_count=1, cur_key=0x1A.
REQ-031 keycode 0x1A->0x04 directly -> events 0x01A then 0x104 pushed on consecutive edges, ev_count=2; popping with ev_ready=1 returns them in that order.
REQ-032 keycode 0x07 for 3 cycles then back to 0x00 (STABLE_CYCLES=4) -> no event, cur_key unchanged.
REQ-033 DEPTH=8, ev_ready=0, 9 alternating 0x00/0x04 stable changes starting from 0x00 -> ev_count=8, overflow=1, first pop returns 0x104; with the FIFO full and ev_ready=1 on the push edge, ev_count stays 8.
REQ-034 Hold 0x04->0x16 and assert Reset on the PRESS-state edge -> ev_count=0 and overflow=0; with 0x16 held, after 6 edges ev_data=0x116.
